// File: rtl/vend_ctrl_if.sv
// Handshake bundle between the vending controller and its coin/selection/dispenser
// environment. The controller uses the slave view; the environment drives the master view.
interface vend_ctrl_if;
   logic       coin_valid;
   logic [4:0] coin;
   logic       sel_valid;
   logic [1:0] sel;
   logic       cancel;
   logic       change_ack;
   logic       coin_ack;
   logic       coin_rej;
   logic       vend;
   logic [1:0] vend_id;
   logic       change_valid;
   logic [4:0] change_coin;
   logic [5:0] saldo;
   logic       busy;

   modport master (
      output coin_valid, coin, sel_valid, sel, cancel, change_ack,
      input  coin_ack, coin_rej, vend, vend_id, change_valid, change_coin, saldo, busy
   );

   modport slave (
      input  coin_valid, coin, sel_valid, sel, cancel, change_ack,
      output coin_ack, coin_rej, vend, vend_id, change_valid, change_coin, saldo, busy
   );
endinterface

// File: rtl/vend_ctrl.sv
// Vending machine controller: collects 5/10/20 coins, vends one of four products
// and pays back change (or a full refund) one coin at a time.
module vend_ctrl #(
   parameter logic [5:0] PRICE0 = 6'd40,
   parameter logic [5:0] PRICE1 = 6'd25,
   parameter logic [5:0] PRICE2 = 6'd35,
   parameter logic [5:0] PRICE3 = 6'd50
) (
   input  logic     clk,
   input  logic     reset,
   vend_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

   state_t     state, nxt;
   logic [5:0] saldo;
   logic [1:0] sel_reg;
   logic       sel_set;
   logic       coin_ack_q, coin_rej_q;

   logic [5:0] price_sel;
   logic [6:0] sum;
   logic [4:0] chg;
   logic       coin_ok, go_vend, accept;

   always_comb begin
      unique case (sel_reg)
         2'd0:    price_sel = PRICE0;
         2'd1:    price_sel = PRICE1;
         2'd2:    price_sel = PRICE2;
         default: price_sel = PRICE3;
      endcase
   end

   always_comb begin
      coin_ok = (bus.coin == 5'd5) || (bus.coin == 5'd10) || (bus.coin == 5'd20);
      sum     = {1'b0, saldo} + {2'b00, bus.coin};
      go_vend = (state == COLLECT) && !bus.cancel && sel_set && (saldo >= price_sel);
      accept  = bus.coin_valid && ((state == IDLE) || (state == COLLECT)) && coin_ok &&
                (sum <= 7'd63) && !bus.cancel && !go_vend;
      if (saldo >= 6'd20)      chg = 5'd20;
      else if (saldo >= 6'd10) chg = 5'd10;
      else if (saldo >= 6'd5)  chg = 5'd5;
      else                     chg = 5'd0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (accept) nxt = COLLECT;
         COLLECT: begin
            if (bus.cancel)   nxt = CHANGE;
            else if (go_vend) nxt = VEND;
         end
         VEND:    nxt = (saldo == price_sel) ? IDLE : CHANGE;
         CHANGE:  if (bus.change_ack && (saldo == {1'b0, chg})) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         saldo      <= '0;
         sel_reg    <= '0;
         sel_set    <= 1'b0;
         coin_ack_q <= 1'b0;
         coin_rej_q <= 1'b0;
      end else begin
         coin_ack_q <= accept;
         coin_rej_q <= bus.coin_valid && !accept;
         unique case (state)
            IDLE, COLLECT: begin
               if (accept) saldo <= sum[5:0];
               // The selection being vended must not change under the price in use.
               if (bus.sel_valid && !go_vend) begin
                  sel_reg <= bus.sel;
                  sel_set <= 1'b1;
               end
               if ((state == COLLECT) && bus.cancel) sel_set <= 1'b0;
            end
            VEND: begin
               saldo   <= saldo - price_sel;
               sel_set <= 1'b0;
            end
            CHANGE: if (bus.change_ack) saldo <= saldo - {1'b0, chg};
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.coin_ack     = coin_ack_q;
      bus.coin_rej     = coin_rej_q;
      bus.vend         = (state == VEND);
      bus.vend_id      = (state == VEND) ? sel_reg : 2'd0;
      bus.change_valid = (state == CHANGE);
      bus.change_coin  = (state == CHANGE) ? chg : 5'd0;
      bus.saldo        = saldo;
      bus.busy         = (state == VEND) || (state == CHANGE);
   end

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: a cycle-by-cycle vector table checked through a scoreboard
// queue, plus a hand-written asynchronous reset sequence from the CHANGE state.
module tb_vend_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vend_ctrl_if bus();

   vend_ctrl #(
      .PRICE0(6'd40),
      .PRICE1(6'd25),
      .PRICE2(6'd35),
      .PRICE3(6'd50)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic       cv;
      logic [4:0] coin;
      logic       sv;
      logic [1:0] sel;
      logic       cn;
      logic       ak;
      logic       ea;
      logic       er;
      logic       ev;
      logic [1:0] eid;
      logic [4:0] ecc;
      logic [5:0] es;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t mk(input logic cv, input logic [4:0] coin, input logic sv,
                               input logic [1:0] sel, input logic cn, input logic ak,
                               input logic ea, input logic er, input logic ev,
                               input logic [1:0] eid, input logic [4:0] ecc,
                               input logic [5:0] es);
      vec_t v;
      v.cv = cv; v.coin = coin; v.sv = sv; v.sel = sel; v.cn = cn; v.ak = ak;
      v.ea = ea; v.er = er; v.ev = ev; v.eid = eid; v.ecc = ecc; v.es = es;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0d want %0d", nm, idx, act, exp);
      end
   endtask

   // change_valid is high exactly when a change coin is offered; busy covers VEND and CHANGE.
   task automatic check_out(input vec_t e, input int idx);
      logic ecv;
      ecv = (e.ecc != 5'd0);
      chk("coin_ack",     idx, {7'd0, bus.coin_ack},     {7'd0, e.ea});
      chk("coin_rej",     idx, {7'd0, bus.coin_rej},     {7'd0, e.er});
      chk("vend",         idx, {7'd0, bus.vend},         {7'd0, e.ev});
      chk("vend_id",      idx, {6'd0, bus.vend_id},      {6'd0, e.eid});
      chk("change_valid", idx, {7'd0, bus.change_valid}, {7'd0, ecv});
      chk("change_coin",  idx, {3'd0, bus.change_coin},  {3'd0, e.ecc});
      chk("saldo",        idx, {2'd0, bus.saldo},        {2'd0, e.es});
      chk("busy",         idx, {7'd0, bus.busy},         {7'd0, (e.ev | ecv)});
   endtask

   task automatic step(input vec_t v, input int idx);
      vec_t e;
      bus.coin_valid = v.cv;
      bus.coin       = v.coin;
      bus.sel_valid  = v.sv;
      bus.sel        = v.sel;
      bus.cancel     = v.cn;
      bus.change_ack = v.ak;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_out(e, idx);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      // exact payment, product 0
      tbl.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  0,  0));
      tbl.push_back(mk(1, 20, 0, 0, 0, 0, 1, 0, 0, 0,  0, 20));
      tbl.push_back(mk(1, 20, 0, 0, 0, 0, 1, 0, 0, 0,  0, 40));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  0, 40));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0,  0));
      // product 1 with change of 5, one stalled cycle
      tbl.push_back(mk(0, 0, 1, 1, 0, 0,  0, 0, 0, 0,  0,  0));
      tbl.push_back(mk(1, 20, 0, 0, 0, 0, 1, 0, 0, 0,  0, 20));
      tbl.push_back(mk(1, 10, 0, 0, 0, 0, 1, 0, 0, 0,  0, 30));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1,  0, 30));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  5,  5));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  5,  5));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0,  0));
      // refund 35 as 20, 10 (stalled 3 cycles), 5
      tbl.push_back(mk(1, 5, 0, 0, 0, 0,  1, 0, 0, 0,  0,  5));
      tbl.push_back(mk(1, 10, 0, 0, 0, 0, 1, 0, 0, 0,  0, 15));
      tbl.push_back(mk(1, 20, 0, 0, 0, 0, 1, 0, 0, 0,  0, 35));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 20, 35));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 10, 15));
      for (int unsigned i = 0; i < 3; i++)
         tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 15));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  5,  5));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0,  0));
      // rejects: bad value, overflow, coin with cancel, coin during CHANGE
      tbl.push_back(mk(1, 7, 0, 0, 0, 0,  0, 1, 0, 0,  0,  0));
      tbl.push_back(mk(1, 20, 0, 0, 0, 0, 1, 0, 0, 0,  0, 20));
      tbl.push_back(mk(1, 20, 0, 0, 0, 0, 1, 0, 0, 0,  0, 40));
      tbl.push_back(mk(1, 20, 0, 0, 0, 0, 1, 0, 0, 0,  0, 60));
      tbl.push_back(mk(1, 5, 0, 0, 0, 0,  0, 1, 0, 0,  0, 60));
      tbl.push_back(mk(1, 10, 0, 0, 1, 0, 0, 1, 0, 0, 20, 60));
      tbl.push_back(mk(1, 5, 0, 0, 0, 1,  0, 1, 0, 0, 20, 40));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 20, 20));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0,  0));
      // coin together with cancel at saldo 20 refunds only 20
      tbl.push_back(mk(1, 20, 0, 0, 0, 0, 1, 0, 0, 0,  0, 20));
      tbl.push_back(mk(1, 20, 0, 0, 1, 0, 0, 1, 0, 0, 20, 20));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0,  0));
      // product 3 at saldo 50, coin in the VEND-transition cycle
      tbl.push_back(mk(1, 20, 0, 0, 0, 0, 1, 0, 0, 0,  0, 20));
      tbl.push_back(mk(1, 20, 0, 0, 0, 0, 1, 0, 0, 0,  0, 40));
      tbl.push_back(mk(1, 10, 0, 0, 0, 0, 1, 0, 0, 0,  0, 50));
      tbl.push_back(mk(0, 0, 1, 3, 0, 0,  0, 0, 0, 0,  0, 50));
      tbl.push_back(mk(1, 5, 0, 0, 0, 0,  0, 1, 1, 3,  0, 50));
      // selection and ack during VEND are ignored: no vend at saldo 40 afterwards
      tbl.push_back(mk(0, 0, 1, 2, 0, 1,  0, 0, 0, 0,  0,  0));
      tbl.push_back(mk(1, 20, 0, 0, 0, 0, 1, 0, 0, 0,  0, 20));
      tbl.push_back(mk(1, 20, 0, 0, 0, 0, 1, 0, 0, 0,  0, 40));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 40));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 20, 40));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 20, 20));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0,  0));

      reset          = 1'b0;
      bus.coin_valid = 1'b0;
      bus.coin       = '0;
      bus.sel_valid  = 1'b0;
      bus.sel        = '0;
      bus.cancel     = 1'b0;
      bus.change_ack = 1'b0;
      #1;
      check_out(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), -1);
      #11 reset = 1'b1;

      foreach (tbl[i]) step(tbl[i], i);

      // asynchronous reset from CHANGE with saldo 15, then resume
      step(mk(1, 5, 0, 0, 0, 0,  1, 0, 0, 0,  0,  5), 100);
      step(mk(1, 10, 0, 0, 0, 0, 1, 0, 0, 0,  0, 15), 101);
      step(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 10, 15), 102);
      bus.cancel = 1'b0;
      #3 reset = 1'b0;
      #1 check_out(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 103);
      #2 reset = 1'b1;
      step(mk(1, 5, 0, 0, 0, 0,  1, 0, 0, 0,  0,  5), 104);
      step(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0,  5), 105);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have parameters: PRICE0, 6'd40, price of product 0; PRICE1, 6'd25, price of product 1; PRICE2, 6'd35, price of product 2; PRICE3, 6'd50, price of product 3; all prices are multiples of 5 and at most 63.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- coin_valid  in  1  a coin is presented this cycle.
- coin  in  5  coin value; only 5, 10 and 20 are valid.
- sel_valid  in  1  a product selection is presented this cycle.
- sel  in  2  product index 0..3.
- cancel  in  1  refund request.
- change_ack  in  1  dispenser has taken the current change coin.
- coin_ack  out  1  one-cycle pulse: coin accepted.
- coin_rej  out  1  one-cycle pulse: coin rejected.
- vend  out  1  one-cycle pulse: product released.
- vend_id  out  2  product index that is valid while vend=1.
- change_valid  out  1  change coin is offered.
- change_coin  out  5  offered change value: 20, 10 or 5.
- saldo  out  6  current credit.
- busy  out  1  high in VEND or CHANGE.

Function
REQ-003 SHALL implement states IDLE, COLLECT, VEND and CHANGE; saldo SHALL be 6-bit unsigned and always a multiple of 5.
REQ-004 Coin acceptance: a coin is accepted only if state is IDLE or COLLECT, coin is in {5,10,20}, saldo+coin<=63 (computed 7-bit), no cancel in the same cycle and no VEND transition in the same cycle; otherwise the coin is rejected.
REQ-005 Accepted coin: saldo SHALL add the coin at the sampling edge, and coin_ack SHALL be high for the following cycle; a rejected coin SHALL assert coin_rej for the following cycle and leave saldo unchanged.
REQ-006 coin_ack and coin_rej SHALL never be high together; both SHALL be low when coin_valid was low.
REQ-007 Selection: sel_valid in IDLE or COLLECT SHALL latch sel into sel_reg and set sel_set; a later sel_valid SHALL overwrite sel_reg; sel_valid in VEND or CHANGE SHALL be ignored.
REQ-008 IDLE: saldo=0; an accepted coin moves the block to COLLECT; cancel SHALL be ignored.
REQ-009 COLLECT, priority highest first:
- (a) cancel moves the block to CHANGE with all credit refunded.
- (b) sel_set and saldo>=price[sel_reg], using the registered saldo, move the block to VEND.
- (c) otherwise the block stays in COLLECT.
REQ-010 VEND: for exactly one cycle vend=1 and vend_id=sel_reg; saldo SHALL become saldo-price[sel_reg] at the exit edge; sel_set SHALL be cleared.
REQ-011 VEND exit: the block goes to IDLE if the remainder is 0, otherwise to CHANGE.
REQ-012 CHANGE: change_valid=1, and change_coin SHALL be the largest of 20/10/5 that is <=saldo, combinational from saldo.
REQ-013 In CHANGE, on change_ack at a posedge saldo SHALL decrease by change_coin; if the result is 0 the block goes to IDLE and change_valid drops, otherwise it stays in CHANGE.
REQ-014 In CHANGE, without change_ack, change_valid and change_coin SHALL hold; change_ack outside CHANGE SHALL be ignored.
REQ-015 In CHANGE, cancel SHALL be ignored; sel_set SHALL be cleared on entry.
REQ-016 busy SHALL equal (state==VEND or state==CHANGE).
REQ-017 change_valid=0 and change_coin=0 SHALL hold outside CHANGE.

Reset
REQ-018 On reset=0 at any time, including mid-VEND or mid-CHANGE, the block SHALL go immediately to IDLE with saldo=0, sel_set=0, sel_reg=0, and coin_ack, coin_rej, vend, vend_id, change_valid, change_coin and busy all 0.
REQ-019 Credit not yet returned at reset SHALL be discarded; after reset release, operation SHALL resume on the first posedge.

Verification
REQ-020 Exact payment: sel=0, then coins 20 and 20 -> two coin_ack pulses, saldo 20 then 40, one vend cycle with vend_id=0, then IDLE with saldo=0 and no change_valid.
REQ-021 Change: sel=1, then coins 20 and 10 -> saldo 30, vend with vend_id=1, then CHANGE offering change_coin=5; after change_ack -> IDLE.
REQ-022 Refund with stalled ack: coins 5, 10, 20, then cancel -> change_coin 20, 10, 5 in order.
- Hold change_ack low for 3 cycles before the 10 -> change_coin stays 10 and saldo stays 15 during the stall.
REQ-023 Rejects:
- coin=7 -> coin_rej, saldo unchanged.
- Three coins of 20 with no selection give saldo 60; coin=5 then -> coin_rej, saldo stays 60.
- A coin during CHANGE -> coin_rej.
REQ-024 Simultaneous events: in COLLECT with saldo 20, coin=20 together with cancel -> coin_rej and refund of 20 only.
- With sel=3 and saldo 50, a coin arriving in the VEND-transition cycle -> coin_rej, vend_id=3.
REQ-025 Reset: assert reset while in CHANGE with saldo 15 -> all outputs 0 immediately without waiting for clk; after release, coin 5 -> coin_ack and saldo 5.
